ap_ctrl_txn_tracker: RTL and testbench

//   Synthesizable probe feeding the dataflow CSV monitor. Watches the HLS top's ap_ctrl_hs

---
 rtl/ap_ctrl_txn_tracker_pkg.sv | 23 ++
 rtl/ap_ctrl_txn_tracker_if.sv | 52 +++++
 rtl/ap_ctrl_txn_tracker_fifo.sv | 58 +++++
 rtl/ap_ctrl_txn_tracker.sv | 143 ++++++++++++++
 tb/tb_ap_ctrl_txn_tracker.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_txn_tracker_pkg.sv
// Shared types and default widths for the ap_ctrl_hs transaction tracker.
// Record layout and tracker state encoding live here.
package ap_trace_pkg;

  localparam int CYC_W_DEF      = 32;
  localparam int ID_W_DEF       = 16;
  localparam int STATE_W_DEF    = 3;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int DROP_W         = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_CONT = 2'd2
  } trk_state_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [CYC_W_DEF-1:0] latency;
    logic [CYC_W_DEF-1:0] iters;
  } trace_rec_t;

endpackage

// File: rtl/ap_ctrl_txn_tracker_if.sv
// Tracker bus: observed ap_ctrl_hs handshake plus the record
// valid/ready stream toward the monitor.
interface ap_ctrl_txn_tracker_if
  import ap_trace_pkg::*;
#(
  parameter int CYC_W   = CYC_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int STATE_W = STATE_W_DEF
);

  logic               ap_start;
  logic               ap_ready;
  logic               ap_done;
  logic               ap_continue;
  logic [STATE_W-1:0] cur_state;
  logic [STATE_W-1:0] iter_start_state;

  logic               rec_valid;
  logic               rec_ready;
  logic [ID_W-1:0]    rec_txn_id;
  logic [CYC_W-1:0]   rec_latency;
  logic [CYC_W-1:0]   rec_iters;

  modport master (
    input  ap_start,
    input  ap_ready,
    input  ap_done,
    input  ap_continue,
    input  cur_state,
    input  iter_start_state,
    input  rec_ready,
    output rec_valid,
    output rec_txn_id,
    output rec_latency,
    output rec_iters
  );

  modport slave (
    output ap_start,
    output ap_ready,
    output ap_done,
    output ap_continue,
    output cur_state,
    output iter_start_state,
    output rec_ready,
    input  rec_valid,
    input  rec_txn_id,
    input  rec_latency,
    input  rec_iters
  );

endinterface

// File: rtl/ap_ctrl_txn_tracker_fifo.sv
// Small synchronous record FIFO; head is read straight from the
// storage registers, so a push becomes visible one cycle later.
module trace_record_fifo
  import ap_trace_pkg::*;
#(
  parameter type rec_t = trace_rec_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  rec_t din,
  output rec_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop frees the slot the push is about to take when full
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ap_ctrl_txn_tracker.sv
// ap_ctrl_hs transaction probe: per-transaction id, start->done
// latency and loop iteration count, buffered for a monitor.
module ap_ctrl_txn_tracker
  import ap_trace_pkg::*;
#(
  parameter int              CYC_W      = CYC_W_DEF,
  parameter int              ID_W       = ID_W_DEF,
  parameter int              STATE_W    = STATE_W_DEF,
  parameter int              FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter bit              ONE_STATE  = 1'b0,
  parameter logic [CYC_W-1:0] CYC_INIT  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  ap_ctrl_txn_tracker_if.master bus,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic                  busy,
  output logic                  proto_err
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_WAIT = WAIT_CONT;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CYC_W-1:0] latency;
    logic [CYC_W-1:0] iters;
  } rec_t;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [CYC_W-1:0]   cyc;
  logic [CYC_W-1:0]   cyc_start;
  logic [CYC_W-1:0]   iters;
  logic [CYC_W-1:0]   iters_nxt;
  logic [ID_W-1:0]    txn_id;
  logic [STATE_W-1:0] prev_state;
  logic               start;
  logic               iter_hit;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  rec_t               push_rec;
  rec_t               head;

  assign iter_hit = (bus.cur_state == bus.iter_start_state) &&
                    (ONE_STATE || prev_state != bus.iter_start_state);

  always_comb begin
    state_nxt = state;
    iters_nxt = iters;
    start     = 1'b0;
    push      = 1'b0;
    push_rec  = '0;
    unique case (state)
      S_IDLE: begin
        if (enable && bus.ap_start) begin
          start     = 1'b1;
          iters_nxt = '0;
          push_rec.id = txn_id;
          if (bus.ap_done) begin
            push      = 1'b1;
            state_nxt = bus.ap_continue ? S_IDLE : S_WAIT;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (iter_hit && iters != '1)
          iters_nxt = iters + CYC_W'(1);
        if (bus.ap_done) begin
          push             = 1'b1;
          push_rec.id      = txn_id;
          push_rec.latency = cyc - cyc_start;
          push_rec.iters   = iters_nxt;
          state_nxt = bus.ap_continue ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ap_continue)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cyc        <= CYC_INIT;
      cyc_start  <= '0;
      iters      <= '0;
      txn_id     <= '0;
      prev_state <= '0;
      drop_cnt   <= '0;
      proto_err  <= 1'b0;
    end else begin
      cyc   <= cyc + CYC_W'(1);
      state <= state_nxt;
      iters <= iters_nxt;
      if (start) begin
        cyc_start  <= cyc;
        prev_state <= bus.cur_state;
      end else if (state == S_RUN) begin
        prev_state <= bus.cur_state;
      end
      // id advances even when the record is dropped
      if (push)
        txn_id <= txn_id + ID_W'(1);
      if (push && full && !pop && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);
      if (state == S_IDLE && (bus.ap_done || bus.ap_ready) && !bus.ap_start)
        proto_err <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE);
  assign pop  = bus.rec_valid & bus.rec_ready;

  trace_record_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.rec_valid   = ~empty;
  assign bus.rec_txn_id  = head.id;
  assign bus.rec_latency = head.latency;
  assign bus.rec_iters   = head.iters;

endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// Directed bench for ap_ctrl_txn_tracker: per-cycle vector table
// followed by hand sequences for overflow, reset and counter wrap.
module tb_ap_ctrl_txn_tracker;

  typedef struct {
    int       reps;
    bit       en;
    bit       st;
    bit       dn;
    bit       ct;
    bit       ar;
    bit       rd;
    bit [2:0] cs;
    bit       eb;
    bit       ev;
    bit       ep;
    bit       ck;
    int       id;
    int       lat;
    int       it;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        en = 1'b1;
  logic        en2 = 1'b1;
  logic [15:0] drop_cnt, drop2;
  logic        busy, busy2;
  logic        perr, perr2;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  ap_ctrl_txn_tracker_if bus ();
  ap_ctrl_txn_tracker_if wbus ();

  ap_ctrl_txn_tracker dut (
    .clock     (clk),
    .reset     (rst_n),
    .enable    (en),
    .bus       (bus),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .proto_err (perr)
  );

  ap_ctrl_txn_tracker #(
    .CYC_INIT (32'hFFFF_FFF8)
  ) u_wrap (
    .clock     (clk),
    .reset     (rst2_n),
    .enable    (en2),
    .bus       (wbus),
    .drop_cnt  (drop2),
    .busy      (busy2),
    .proto_err (perr2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int reps, bit en_, bit st, bit dn, bit ct,
                              bit ar, bit rd, bit [2:0] cs, bit eb,
                              bit ev, bit ep, bit ck, int id, int lat,
                              int it);
    vec_t v;
    v.reps = reps; v.en = en_; v.st = st; v.dn = dn; v.ct = ct;
    v.ar = ar; v.rd = rd; v.cs = cs; v.eb = eb; v.ev = ev;
    v.ep = ep; v.ck = ck; v.id = id; v.lat = lat; v.it = it;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.ap_start = 1'b0;
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
    bus.ap_continue = 1'b1;
    bus.cur_state = 3'b001;
    bus.rec_ready = 1'b0;
    en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int lat);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    repeat (lat - 1) tick();
    bus.ap_done = 1'b1;
    tick();
    bus.ap_done = 1'b0;
  endtask

  task automatic pop_one();
    bus.rec_ready = 1'b1;
    tick();
    bus.rec_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus.iter_start_state = 3'b010;
    wbus.ap_start = 1'b0;
    wbus.ap_ready = 1'b0;
    wbus.ap_done = 1'b0;
    wbus.ap_continue = 1'b1;
    wbus.cur_state = 3'b001;
    wbus.iter_start_state = 3'b010;
    wbus.rec_ready = 1'b0;

    //       rp en st dn ct ar rd cs      eb ev ep ck id lat it
    vq.push_back(mk(1, 1,1,0,1,0,0,3'b001, 1,0,0,0, 0,0,0));
    vq.push_back(mk(2, 1,0,0,1,0,0,3'b010, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,0,0,1,0,0,3'b100, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,0,0,1,0,0,3'b010, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,0,0,1,0,0,3'b100, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,0,0,1,0,0,3'b010, 1,0,0,0, 0,0,0));
    vq.push_back(mk(8, 1,0,0,1,0,0,3'b100, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,0,1,1,0,0,3'b001, 0,1,0,1, 0,15,3));
    vq.push_back(mk(2, 1,0,0,1,0,0,3'b001, 0,1,0,1, 0,15,3));
    vq.push_back(mk(1, 1,0,0,1,0,1,3'b001, 0,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,1,1,1,0,1,3'b001, 0,1,0,1, 1,0,0));
    vq.push_back(mk(1, 1,0,0,1,0,1,3'b001, 0,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,1,0,1,0,0,3'b001, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,1,1,0,0,0,3'b100, 1,1,0,1, 2,1,0));
    vq.push_back(mk(4, 1,1,0,0,0,0,3'b001, 1,1,0,1, 2,1,0));
    vq.push_back(mk(1, 1,1,0,1,0,0,3'b001, 0,1,0,1, 2,1,0));
    vq.push_back(mk(1, 1,1,0,1,0,0,3'b001, 1,1,0,1, 2,1,0));
    vq.push_back(mk(1, 1,0,1,1,0,0,3'b001, 0,1,0,1, 2,1,0));
    vq.push_back(mk(1, 1,0,0,1,0,1,3'b001, 0,1,0,1, 3,1,0));
    vq.push_back(mk(1, 1,0,0,1,0,1,3'b001, 0,0,0,0, 0,0,0));
    vq.push_back(mk(2, 0,1,0,1,0,0,3'b001, 0,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,1,0,1,0,0,3'b001, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 0,0,0,1,0,0,3'b010, 1,0,0,0, 0,0,0));
    vq.push_back(mk(1, 0,0,1,1,0,0,3'b001, 0,1,0,1, 4,2,1));
    vq.push_back(mk(1, 0,0,0,1,0,1,3'b001, 0,0,0,0, 0,0,0));
    vq.push_back(mk(1, 1,0,0,1,1,0,3'b001, 0,0,1,0, 0,0,0));
    vq.push_back(mk(1, 1,0,0,1,0,0,3'b001, 0,0,1,0, 0,0,0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst valid", 64'(bus.rec_valid), 64'(0));
    chk("rst perr", 64'(perr), 64'(0));
    chk("rst drop", 64'(drop_cnt), 64'(0));
    chk("rst id", 64'(bus.rec_txn_id), 64'(0));
    chk("rst lat", 64'(bus.rec_latency), 64'(0));
    chk("rst iters", 64'(bus.rec_iters), 64'(0));
    rst_n = 1'b1;

    foreach (vq[i]) begin
      for (int r = 0; r < vq[i].reps; r++) begin
        en = vq[i].en;
        bus.ap_start = vq[i].st;
        bus.ap_done = vq[i].dn;
        bus.ap_continue = vq[i].ct;
        bus.ap_ready = vq[i].ar;
        bus.rec_ready = vq[i].rd;
        bus.cur_state = vq[i].cs;
        tick();
        chk($sformatf("v%0d busy", i), 64'(busy), 64'(vq[i].eb));
        chk($sformatf("v%0d valid", i), 64'(bus.rec_valid), 64'(vq[i].ev));
        chk($sformatf("v%0d perr", i), 64'(perr), 64'(vq[i].ep));
        if (vq[i].ck) begin
          chk($sformatf("v%0d id", i), 64'(bus.rec_txn_id), 64'(vq[i].id));
          chk($sformatf("v%0d lat", i), 64'(bus.rec_latency), 64'(vq[i].lat));
          chk($sformatf("v%0d iters", i), 64'(bus.rec_iters), 64'(vq[i].it));
        end
      end
    end

    // overflow: 10 transactions into 8 slots with the consumer stalled
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      run_txn(2);
      tick();
    end
    chk("ovf drop", 64'(drop_cnt), 64'(2));
    chk("ovf valid", 64'(bus.rec_valid), 64'(1));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf id%0d", k), 64'(bus.rec_txn_id), 64'(k));
      chk($sformatf("ovf lat%0d", k), 64'(bus.rec_latency), 64'(2));
      pop_one();
    end
    chk("ovf drained", 64'(bus.rec_valid), 64'(0));
    run_txn(4);
    chk("ovf next id", 64'(bus.rec_txn_id), 64'(10));
    chk("ovf next lat", 64'(bus.rec_latency), 64'(4));
    pop_one();

    // reset while RUN with two records queued
    run_txn(2);
    run_txn(2);
    chk("mid queued", 64'(bus.rec_valid), 64'(1));
    chk("mid head", 64'(bus.rec_txn_id), 64'(11));
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    chk("mid busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", 64'(bus.rec_valid), 64'(0));
    chk("mid rst busy", 64'(busy), 64'(0));
    chk("mid rst drop", 64'(drop_cnt), 64'(0));
    tick();
    rst_n = 1'b1;
    run_txn(3);
    chk("post rst valid", 64'(bus.rec_valid), 64'(1));
    chk("post rst id", 64'(bus.rec_txn_id), 64'(0));
    chk("post rst lat", 64'(bus.rec_latency), 64'(3));
    chk("post rst iters", 64'(bus.rec_iters), 64'(0));

    // counter wrap: start sampled at 0xFFFF_FFFE, done 3 cycles later
    rst2_n = 1'b1;
    repeat (6) tick();
    wbus.ap_start = 1'b1;
    tick();
    wbus.ap_start = 1'b0;
    chk("wrap busy", 64'(busy2), 64'(1));
    repeat (2) tick();
    wbus.ap_done = 1'b1;
    tick();
    wbus.ap_done = 1'b0;
    chk("wrap valid", 64'(wbus.rec_valid), 64'(1));
    chk("wrap id", 64'(wbus.rec_txn_id), 64'(0));
    chk("wrap lat", 64'(wbus.rec_latency), 64'(3));
    chk("wrap perr", 64'(perr2), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
